// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding and default PC width for the program-counter sequencer.
package pc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_t;
  localparam int PC_W = 12;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/prog_ctr_seq.sv
// prog_ctr_seq: PC sequencer with start/done handshake, relative branches,
// run/branch counters and a runaway watchdog.
module prog_ctr_seq
  import pc_pkg::*;
#(
  parameter int D          = PC_W,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 40000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             BranchRel,
  input  logic             CondZero,
  input  logic [D-1:0]     Target,
  output logic [D-1:0]     ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] BranchCnt
);
  pc_state_t state, state_nx;
  logic [D-1:0] pc_nx;
  logic run, live, wdog, adv, taken, to_nx;
  assign run   = state == RUN;
  assign live  = run && !Stall;
  assign wdog  = live && CycleCnt == CNT_W'(MAX_CYCLES - 1);
  assign adv   = live && !wdog && !Halt;
  assign taken = adv && BranchRel && CondZero;
  always_comb begin
    state_nx = Start ? RUN : (live && (wdog || Halt)) ? HALT : state;
    pc_nx    = Start ? D'(START_ADDR) : !adv ? ProgCtr : taken ? ProgCtr + Target : ProgCtr + 1'b1;
    to_nx    = Start ? 1'b0 : wdog ? 1'b1 : Timeout;
  end
  always_ff @(posedge Clk)
    if (Reset) begin
      state   <= IDLE;
      ProgCtr <= '0;
      Timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      ProgCtr <= pc_nx;
      Timeout <= to_nx;
    end
  assign Running = state == RUN;
  assign Done    = state == HALT;
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(Clk), .rst(Reset), .clr(Start), .inc(run), .cnt(CycleCnt)
  );
  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk(Clk), .rst(Reset), .clr(Start), .inc(taken), .cnt(BranchCnt)
  );
endmodule

// File: tb/tb_prog_ctr_seq.sv
// tb_prog_ctr_seq: directed scenarios plus random stimulus checked every cycle against a reference model.
module tb_prog_ctr_seq;
  localparam int D = 12, CNT_W = 16, MAXC = 64, SADDR = 0;
  localparam int PCMOD = 1 << D, CMAX = (1 << CNT_W) - 1;
  logic Clk = 1'b0, Reset = 1'b0, Start = 1'b0, Halt = 1'b0, Stall = 1'b0;
  logic BranchRel = 1'b0, CondZero = 1'b0;
  logic [D-1:0] Target = '0;
  logic [D-1:0] ProgCtr;
  logic Running, Done, Timeout;
  logic [CNT_W-1:0] CycleCnt, BranchCnt;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  int m_mode = 0;
  int m_pc = 0, m_cyc = 0, m_br = 0, m_to = 0;

  prog_ctr_seq #(.D(D), .START_ADDR(SADDR), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .BranchRel(BranchRel), .CondZero(CondZero), .Target(Target),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .Timeout(Timeout),
    .CycleCnt(CycleCnt), .BranchCnt(BranchCnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: mode 0 idle, 1 running, 2 halted; one call per clock using the inputs of that clock.
  task automatic model_update();
    int cyc_before;
    if (Reset) begin
      m_mode = 0; m_pc = 0; m_cyc = 0; m_br = 0; m_to = 0;
    end else if (Start) begin
      m_mode = 1; m_pc = SADDR; m_cyc = 0; m_br = 0; m_to = 0;
    end else if (m_mode == 1) begin
      cyc_before = m_cyc;
      m_cyc = (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
      if (!Stall) begin
        if (cyc_before == MAXC - 1) begin
          m_mode = 2; m_to = 1;
        end else if (Halt) m_mode = 2;
        else if (BranchRel && CondZero) begin
          m_pc = (m_pc + int'(Target)) % PCMOD;
          m_br = (m_br < CMAX) ? m_br + 1 : CMAX;
        end else m_pc = (m_pc + 1) % PCMOD;
      end
    end
  endtask

  always @(negedge Clk) if (chk_en) begin
    chk("ProgCtr", int'(ProgCtr), m_pc);
    chk("Running", int'(Running), int'(m_mode == 1));
    chk("Done", int'(Done), int'(m_mode == 2));
    chk("Timeout", int'(Timeout), m_to);
    chk("CycleCnt", int'(CycleCnt), m_cyc);
    chk("BranchCnt", int'(BranchCnt), m_br);
  end

  task automatic step(input logic r, s, h, st, b, c, input logic [D-1:0] t);
    Reset = r; Start = s; Halt = h; Stall = st; BranchRel = b; CondZero = c; Target = t;
    @(posedge Clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, 0, '0);
    chk_en = 1;
    chk("rst_pc", int'(ProgCtr), 0);
    chk("rst_running", int'(Running), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_cyc", int'(CycleCnt), 0);
    chk("rst_br", int'(BranchCnt), 0);
    step(0, 0, 1, 0, 1, 1, 12'h005);
    chk("idle_ignores", int'(ProgCtr), 0);
    step(0, 1, 0, 0, 0, 0, '0);
    chk("start_running", int'(Running), 1);
    idle(5);
    chk("seq5_pc", int'(ProgCtr), 5);
    chk("seq5_cyc", int'(CycleCnt), 5);
    idle(25);
    chk("at30_pc", int'(ProgCtr), 30);
    step(0, 0, 0, 0, 1, 1, 12'hFE6);
    chk("taken_back_pc", int'(ProgCtr), 4);
    chk("taken_back_br", int'(BranchCnt), 1);
    idle(26);
    step(0, 0, 0, 0, 1, 0, 12'hFE6);
    chk("not_taken_pc", int'(ProgCtr), 31);
    chk("not_taken_br", int'(BranchCnt), 1);
    step(0, 1, 0, 0, 0, 0, '0);
    idle(5);
    step(0, 0, 0, 0, 1, 1, 12'hF53);
    chk("wrap_back_pc", int'(ProgCtr), 3928);
    step(0, 0, 0, 0, 1, 1, 12'h0A7);
    chk("at_top_pc", int'(ProgCtr), 4095);
    idle(1);
    chk("wrap_top_pc", int'(ProgCtr), 0);
    chk("wrap_br", int'(BranchCnt), 2);
    step(0, 0, 0, 0, 1, 1, 12'h000);
    chk("self_loop_pc", int'(ProgCtr), 0);
    step(0, 1, 0, 0, 0, 0, '0);
    idle(3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 1, 12'h010);
    chk("stall_pc", int'(ProgCtr), 3);
    chk("stall_running", int'(Running), 1);
    chk("stall_cyc", int'(CycleCnt), 6);
    step(0, 0, 1, 0, 0, 0, '0);
    chk("halt_done", int'(Done), 1);
    chk("halt_pc", int'(ProgCtr), 3);
    chk("halt_cyc", int'(CycleCnt), 7);
    chk("halt_to", int'(Timeout), 0);
    idle(2);
    chk("halt_hold_cyc", int'(CycleCnt), 7);
    step(0, 1, 0, 0, 0, 0, '0);
    idle(MAXC);
    chk("wdog_done", int'(Done), 1);
    chk("wdog_to", int'(Timeout), 1);
    chk("wdog_cyc", int'(CycleCnt), MAXC);
    chk("wdog_pc", int'(ProgCtr), MAXC - 1);
    step(0, 1, 0, 0, 0, 0, '0);
    chk("restart_to", int'(Timeout), 0);
    idle(4);
    step(0, 1, 0, 0, 0, 0, '0);
    chk("midrun_pc", int'(ProgCtr), 0);
    chk("midrun_cyc", int'(CycleCnt), 0);
    chk("midrun_done", int'(Done), 0);
    idle(2);
    step(1, 1, 0, 0, 0, 0, '0);
    chk("reset_wins", int'(Running), 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           D'($urandom));
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
